fmul_36bit_arbiter: RTL and testbench

Shares one fmul_36bit pipeline between P_REQ_N independent requesters. Requests are granted round-robin and issued through a registered stage. The requester ID of every accepted operation is tracked in an in-order tag FIFO. Each result is routed back to the requester that issued it, and downstream backpressure from that requester is passed through to the multiplier.

---
 rtl/fmul_36bit_arbiter_if.sv | 30 +++
 rtl/fmul_36bit_arbiter.sv | 135 +++++++++++++
 tb/tb_fmul_36bit_arbiter.sv | 472 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fmul_36bit_arbiter_if.sv
// rtl/fmul_36bit_arbiter_if.sv - requester and multiplier bus bundle for fmul_36bit_arbiter
interface fmul_36bit_arbiter_if #(
    parameter int P_REQ_N = 4
);
    logic [P_REQ_N-1:0]    iREQ;
    logic [P_REQ_N-1:0]    oBUSY;
    logic [36*P_REQ_N-1:0] iDATA_A;
    logic [36*P_REQ_N-1:0] iDATA_B;
    logic                  oFMUL_REQ;
    logic                  iFMUL_BUSY;
    logic [35:0]           oFMUL_DATA_A;
    logic [35:0]           oFMUL_DATA_B;
    logic                  iFMUL_VALID;
    logic                  oFMUL_BUSY;
    logic [35:0]           iFMUL_DATA;
    logic [P_REQ_N-1:0]    oVALID;
    logic [P_REQ_N-1:0]    iBUSY;
    logic [35:0]           oDATA;
    logic                  oERR;

    modport slave (
        input  iREQ, iDATA_A, iDATA_B, iFMUL_BUSY, iFMUL_VALID, iFMUL_DATA, iBUSY,
        output oBUSY, oFMUL_REQ, oFMUL_DATA_A, oFMUL_DATA_B, oFMUL_BUSY, oVALID, oDATA, oERR
    );

    modport master (
        output iREQ, iDATA_A, iDATA_B, iFMUL_BUSY, iFMUL_VALID, iFMUL_DATA, iBUSY,
        input  oBUSY, oFMUL_REQ, oFMUL_DATA_A, oFMUL_DATA_B, oFMUL_BUSY, oVALID, oDATA, oERR
    );
endinterface

// File: rtl/fmul_36bit_arbiter.sv
// rtl/fmul_36bit_arbiter.sv - round-robin sharing of one fmul_36bit pipeline with in-order result routing
module fmul_36bit_arbiter #(
    parameter int P_REQ_N = 4,
    parameter int P_DEPTH = 8
) (
    input  logic                 iCLOCK,
    input  logic                 iRESET_SYNC,
    fmul_36bit_arbiter_if.slave  bus
);
    localparam int TW = $clog2(P_REQ_N);
    localparam int IW = TW + 1;
    localparam int PW = $clog2(P_DEPTH);
    localparam int CW = PW + 1;

    logic              issue_valid;
    logic [35:0]       issue_a;
    logic [35:0]       issue_b;
    logic [TW-1:0]     issue_tag;
    logic [TW-1:0]     rr_ptr;
    logic              err;

    logic [TW-1:0]     tag_mem [P_DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count;

    logic [CW-1:0]     inflight;
    logic              can_issue;
    logic              grant_found;
    logic [TW-1:0]     grant;
    logic [IW-1:0]     idx;
    logic              transfer;
    logic              accept;
    logic              fifo_empty;
    logic [TW-1:0]     head;
    logic              pop;
    logic [P_REQ_N-1:0] busy_vec;
    logic [P_REQ_N-1:0] valid_vec;

    // Credit uses registered occupancy only; a pop frees its slot on the following cycle.
    assign inflight  = count + CW'(issue_valid);
    assign can_issue = (inflight < CW'(P_DEPTH)) && (!issue_valid || !bus.iFMUL_BUSY);

    always_comb begin
        grant_found = 1'b0;
        grant       = rr_ptr;
        idx         = '0;
        for (int k = 0; k < P_REQ_N; k++) begin
            idx = {1'b0, rr_ptr} + IW'(k);
            if (idx >= IW'(P_REQ_N)) begin
                idx = idx - IW'(P_REQ_N);
            end
            if (!grant_found && bus.iREQ[idx[TW-1:0]]) begin
                grant_found = 1'b1;
                grant       = idx[TW-1:0];
            end
        end
    end

    always_comb begin
        busy_vec = '1;
        if (!iRESET_SYNC && grant_found) begin
            busy_vec[grant] = !can_issue;
        end
    end

    assign transfer   = grant_found && can_issue && !iRESET_SYNC;
    assign accept     = issue_valid && !bus.iFMUL_BUSY;
    assign fifo_empty = (count == '0);
    assign head       = tag_mem[rd_ptr];
    assign pop        = bus.iFMUL_VALID && !fifo_empty && !bus.iBUSY[head];

    always_comb begin
        valid_vec = '0;
        if (!fifo_empty) begin
            valid_vec[head] = bus.iFMUL_VALID;
        end
    end

    assign bus.oBUSY        = busy_vec;
    assign bus.oFMUL_REQ    = issue_valid;
    assign bus.oFMUL_DATA_A = issue_a;
    assign bus.oFMUL_DATA_B = issue_b;
    assign bus.oVALID       = valid_vec;
    assign bus.oDATA        = bus.iFMUL_DATA;
    assign bus.oFMUL_BUSY   = !fifo_empty && bus.iBUSY[head];
    assign bus.oERR         = err;

    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            issue_valid <= 1'b0;
            rr_ptr      <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            err         <= 1'b0;
        end else begin
            if (transfer) begin
                issue_valid <= 1'b1;
                rr_ptr      <= (grant == TW'(P_REQ_N - 1)) ? '0 : grant + 1'b1;
            end else if (accept) begin
                issue_valid <= 1'b0;
            end
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (accept && !pop) begin
                count <= count + 1'b1;
            end else if (!accept && pop) begin
                count <= count - 1'b1;
            end
            // A result with no outstanding tag cannot be routed; it is dropped and flagged.
            if (bus.iFMUL_VALID && fifo_empty) begin
                err <= 1'b1;
            end
        end
    end

    always_ff @(posedge iCLOCK) begin
        if (transfer) begin
            issue_a   <= bus.iDATA_A[36*grant +: 36];
            issue_b   <= bus.iDATA_B[36*grant +: 36];
            issue_tag <= grant;
        end
    end

    always_ff @(posedge iCLOCK) begin
        if (accept && !iRESET_SYNC) begin
            tag_mem[wr_ptr] <= issue_tag;
        end
    end
endmodule

// File: tb/tb_fmul_36bit_arbiter.sv
// tb/tb_fmul_36bit_arbiter.sv - scoreboard bench for fmul_36bit_arbiter with a behavioural fmul_36bit
module tb_fmul_36bit_arbiter;
    localparam logic [35:0] K_1P5 = 36'h3_FC00_0000;
    localparam logic [35:0] K_2P0 = 36'h4_0000_0000;
    localparam logic [35:0] K_3P0 = 36'h4_0400_0000;

    typedef struct {
        int          id;
        logic [35:0] d;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    fmul_36bit_arbiter_if #(.P_REQ_N(4)) bus ();

    fmul_36bit_arbiter #(.P_REQ_N(4), .P_DEPTH(8)) dut (
        .iCLOCK      (clk),
        .iRESET_SYNC (rst),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    exp_t        sb[$];
    int          grant_log[$];
    int          delivered[4];
    int          n_accept = 0;
    int          remaining[4];
    logic [35:0] cur_a[4];
    logic [35:0] cur_b[4];
    logic [35:0] last_a;
    logic [35:0] last_b;
    bit          fixed_ops = 1'b0;
    bit          inj_valid = 1'b0;
    bit          force_fbusy = 1'b0;

    function automatic logic [35:0] fmul36(input logic [35:0] a, input logic [35:0] b);
        logic [55:0] p;
        logic [8:0]  e;
        logic [26:0] f;
        p = {28'd0, 1'b1, a[26:0]} * {28'd0, 1'b1, b[26:0]};
        e = {1'b0, a[34:27]} + {1'b0, b[34:27]} - 9'd127;
        if (p[55]) begin
            f = p[54:28];
            e = e + 9'd1;
        end else begin
            f = p[53:27];
        end
        return {a[35] ^ b[35], e[7:0], f};
    endfunction

    // Behavioural multiplier: in-order, 4-cycle latency, 8-entry capacity, stalls on iDATA_BUSY.
    logic [35:0] fm_d [8];
    int          fm_rdy [8];
    logic [2:0]  fm_wp, fm_rp;
    int          fm_cnt = 0;
    int          cyc = 0;
    logic        fm_valid, fm_pop, fm_push;

    assign fm_valid        = (fm_cnt > 0) && (fm_rdy[fm_rp] <= cyc);
    assign fm_pop          = fm_valid && !bus.oFMUL_BUSY;
    assign fm_push         = bus.oFMUL_REQ && !bus.iFMUL_BUSY;
    assign bus.iFMUL_BUSY  = (fm_cnt >= 8) || force_fbusy;
    assign bus.iFMUL_VALID = fm_valid || inj_valid;
    assign bus.iFMUL_DATA  = inj_valid ? 36'h0_DEAD_BEEF : fm_d[fm_rp];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            fm_wp  <= '0;
            fm_rp  <= '0;
            fm_cnt <= 0;
        end else begin
            if (fm_pop) fm_rp <= fm_rp + 3'd1;
            if (fm_push) begin
                fm_d[fm_wp]   <= fmul36(bus.oFMUL_DATA_A, bus.oFMUL_DATA_B);
                fm_rdy[fm_wp] <= cyc + 4;
                fm_wp         <= fm_wp + 3'd1;
            end
            fm_cnt <= fm_cnt + int'(fm_push) - int'(fm_pop);
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.oFMUL_REQ && !bus.iFMUL_BUSY) n_accept++;
                if (bus.oVALID != 4'b0000) begin
                    checks++;
                    if ($countones(bus.oVALID) > 1) begin
                        errors++;
                        $display("FAIL valid_onehot: oVALID=%b, required one-hot", bus.oVALID);
                    end
                end
                for (int i = 0; i < 4; i++) begin
                    if (bus.oVALID[i] && !bus.iBUSY[i]) begin
                        checks++;
                        if (sb.size() == 0) begin
                            errors++;
                            $display("FAIL result_unexpected: oVALID=%b data=%h, required no result", bus.oVALID, bus.oDATA);
                        end else begin
                            e = sb.pop_front();
                            if (i != e.id || bus.oDATA !== e.d) begin
                                errors++;
                                $display("FAIL result_route: got req %0d data %h, required req %0d data %h", i, bus.oDATA, e.id, e.d);
                            end
                            delivered[i]++;
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic load_op(input int i);
        if (fixed_ops) begin
            cur_a[i] = K_1P5;
            cur_b[i] = K_2P0;
        end else begin
            cur_a[i] = {1'($urandom), 8'($urandom_range(150, 110)), 27'($urandom)};
            cur_b[i] = {1'($urandom), 8'($urandom_range(150, 110)), 27'($urandom)};
        end
        bus.iDATA_A[36*i +: 36] = cur_a[i];
        bus.iDATA_B[36*i +: 36] = cur_b[i];
    endtask

    task automatic drive_req();
        for (int i = 0; i < 4; i++) bus.iREQ[i] = (remaining[i] > 0);
    endtask

    function automatic bit any_remaining();
        for (int i = 0; i < 4; i++) if (remaining[i] > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic clear_delivered();
        for (int i = 0; i < 4; i++) delivered[i] = 0;
    endtask

    task automatic step();
        bit x[4];
        int nx = 0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            x[i] = 1'b0;
            if (bus.iREQ[i] && !bus.oBUSY[i]) begin
                x[i] = 1'b1;
                nx++;
                sb.push_back('{id: i, d: (fixed_ops ? K_3P0 : fmul36(cur_a[i], cur_b[i]))});
                grant_log.push_back(i);
                last_a = cur_a[i];
                last_b = cur_b[i];
            end
        end
        if (nx > 0) begin
            checks++;
            if (nx != 1) begin
                errors++;
                $display("FAIL single_grant: %0d transfers in one cycle, required 1", nx);
            end
        end
        @(posedge clk);
        #1;
        if (nx == 1) begin
            checks++;
            if (bus.oFMUL_REQ !== 1'b1 || bus.oFMUL_DATA_A !== last_a || bus.oFMUL_DATA_B !== last_b) begin
                errors++;
                $display("FAIL issue_latency: oFMUL_REQ=%b A=%h B=%h, required 1 A=%h B=%h",
                         bus.oFMUL_REQ, bus.oFMUL_DATA_A, bus.oFMUL_DATA_B, last_a, last_b);
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (x[i]) begin
                remaining[i]--;
                load_op(i);
            end
        end
        drive_req();
    endtask

    task automatic run_until_done(input int bound, output int n);
        n = 0;
        while (any_remaining() && n < bound) begin
            step();
            n++;
        end
        checks++;
        if (any_remaining()) begin
            errors++;
            $display("FAIL issue_timeout: requests still pending after %0d cycles, required none", n);
        end
    endtask

    task automatic drain(input int bound);
        int n = 0;
        while (sb.size() > 0 && n < bound) begin
            @(posedge clk);
            n++;
        end
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) remaining[i] = 0;
        drive_req();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        grant_log.delete();
        clear_delivered();
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        bus.iREQ    = 4'hF;
        bus.iBUSY   = 4'h0;
        bus.iDATA_A = '0;
        bus.iDATA_B = '0;
        @(negedge clk);
        checks++;
        if (bus.oBUSY !== 4'hF) begin
            errors++;
            $display("FAIL reset_busy: oBUSY=%b, required 1111", bus.oBUSY);
        end
        @(posedge clk);
        #1;
        rst      = 1'b0;
        bus.iREQ = 4'h0;
        checks++;
        if (bus.oFMUL_REQ !== 1'b0 || bus.oVALID !== 4'h0 || bus.oERR !== 1'b0 || bus.oFMUL_BUSY !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: req=%b valid=%b err=%b fbusy=%b, required 0 0000 0 0",
                     bus.oFMUL_REQ, bus.oVALID, bus.oERR, bus.oFMUL_BUSY);
        end
        clear_delivered();
    endtask

    task automatic test_single_stream();
        int n;
        fixed_ops    = 1'b1;
        remaining[0] = 20;
        load_op(0);
        drive_req();
        run_until_done(100, n);
        checks++;
        if (n != 20) begin
            errors++;
            $display("FAIL single_throughput: %0d cycles for 20 ops, required 20", n);
        end
        drain(100);
        fixed_ops = 1'b0;
        checks++;
        if (delivered[0] != 20 || delivered[1] != 0 || delivered[2] != 0 || delivered[3] != 0) begin
            errors++;
            $display("FAIL single_delivered: %0d/%0d/%0d/%0d, required 20/0/0/0",
                     delivered[0], delivered[1], delivered[2], delivered[3]);
        end
    endtask

    task automatic test_round_robin();
        int n;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            remaining[i] = 4;
            load_op(i);
        end
        drive_req();
        run_until_done(100, n);
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (k >= grant_log.size() || grant_log[k] != k % 4) begin
                errors++;
                $display("FAIL rr_order: grant %0d was %0d, required %0d",
                         k, (k < grant_log.size()) ? grant_log[k] : -1, k % 4);
            end
        end
        drain(100);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (delivered[i] != 4) begin
                errors++;
                $display("FAIL rr_delivered: requester %0d got %0d results, required 4", i, delivered[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int          n;
        logic [3:0]  ev;
        clear_delivered();
        grant_log.delete();
        bus.iBUSY = 4'hF;
        for (int i = 0; i < 4; i++) begin
            remaining[i] = 3;
            load_op(i);
        end
        drive_req();
        repeat (14) step();
        checks++;
        if (bus.oFMUL_BUSY !== 1'b1 || bus.oBUSY !== 4'hF || bus.oFMUL_REQ !== 1'b0) begin
            errors++;
            $display("FAIL bp_stall: fbusy=%b oBUSY=%b req=%b, required 1 1111 0",
                     bus.oFMUL_BUSY, bus.oBUSY, bus.oFMUL_REQ);
        end
        checks++;
        if (grant_log.size() != 8 || sb.size() != 8) begin
            errors++;
            $display("FAIL bp_inflight: issued %0d pending %0d, required 8 8", grant_log.size(), sb.size());
        end
        if (sb.size() > 0) begin
            ev = 4'b0001 << sb[0].id;
            checks++;
            if (bus.oVALID !== ev) begin
                errors++;
                $display("FAIL bp_head_valid: oVALID=%b, required %b", bus.oVALID, ev);
            end
        end
        bus.iBUSY = 4'h0;
        run_until_done(200, n);
        drain(100);
        checks++;
        if (delivered[0] + delivered[1] + delivered[2] + delivered[3] != 12) begin
            errors++;
            $display("FAIL bp_delivered: %0d results, required 12",
                     delivered[0] + delivered[1] + delivered[2] + delivered[3]);
        end
    endtask

    task automatic test_issue_stall();
        int acc0;
        int d0;
        d0           = delivered[2];
        force_fbusy  = 1'b1;
        remaining[2] = 1;
        load_op(2);
        drive_req();
        step();
        acc0 = n_accept;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (bus.oFMUL_REQ !== 1'b1 || bus.oFMUL_DATA_A !== last_a || bus.oFMUL_DATA_B !== last_b) begin
                errors++;
                $display("FAIL stall_hold: req=%b A=%h B=%h, required 1 A=%h B=%h",
                         bus.oFMUL_REQ, bus.oFMUL_DATA_A, bus.oFMUL_DATA_B, last_a, last_b);
            end
        end
        checks++;
        if (n_accept != acc0) begin
            errors++;
            $display("FAIL stall_no_accept: %0d accepts while stalled, required 0", n_accept - acc0);
        end
        @(posedge clk);
        #1;
        force_fbusy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (n_accept != acc0 + 1) begin
            errors++;
            $display("FAIL stall_accept_once: %0d accepts after release, required 1", n_accept - acc0);
        end
        drain(100);
        checks++;
        if (delivered[2] != d0 + 1) begin
            errors++;
            $display("FAIL stall_delivered: %0d results, required 1", delivered[2] - d0);
        end
    endtask

    task automatic test_error();
        checks++;
        if (bus.oERR !== 1'b0) begin
            errors++;
            $display("FAIL err_initial: oERR=%b, required 0", bus.oERR);
        end
        inj_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.oVALID !== 4'h0) begin
            errors++;
            $display("FAIL err_no_valid: oVALID=%b, required 0000", bus.oVALID);
        end
        @(posedge clk);
        #1;
        inj_valid = 1'b0;
        checks++;
        if (bus.oERR !== 1'b1) begin
            errors++;
            $display("FAIL err_set: oERR=%b, required 1", bus.oERR);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.oERR !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky: oERR=%b, required 1", bus.oERR);
        end
    endtask

    task automatic test_reset_inflight();
        int n;
        remaining[0] = 5;
        load_op(0);
        drive_req();
        run_until_done(50, n);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        grant_log.delete();
        clear_delivered();
        checks++;
        if (bus.oFMUL_REQ !== 1'b0 || bus.oVALID !== 4'h0 || bus.oERR !== 1'b0 || bus.oFMUL_BUSY !== 1'b0) begin
            errors++;
            $display("FAIL midreset_state: req=%b valid=%b err=%b fbusy=%b, required 0 0000 0 0",
                     bus.oFMUL_REQ, bus.oVALID, bus.oERR, bus.oFMUL_BUSY);
        end
        for (int i = 0; i < 4; i++) begin
            remaining[i] = 1;
            load_op(i);
        end
        drive_req();
        step();
        checks++;
        if (grant_log.size() == 0 || grant_log[0] != 0) begin
            errors++;
            $display("FAIL midreset_first_grant: %0d, required 0", (grant_log.size() > 0) ? grant_log[0] : -1);
        end
        run_until_done(50, n);
        drain(100);
        checks++;
        if (delivered[0] + delivered[1] + delivered[2] + delivered[3] != 4) begin
            errors++;
            $display("FAIL midreset_delivered: %0d results, required 4",
                     delivered[0] + delivered[1] + delivered[2] + delivered[3]);
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) remaining[i] = 0;
        test_reset();
        test_single_stream();
        test_round_robin();
        test_backpressure();
        test_issue_stall();
        test_error();
        test_reset_inflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
